// File: rtl/uart_rom_loader_pkg.sv
// Shared constants and FSM encoding for the UART ROM loader.
// Host tools rely on the same byte values.
package uart_rom_loader_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'h55;
  localparam logic [7:0] CMD_WRITE    = 8'h01;
  localparam logic [7:0] CMD_RUN      = 8'h02;
  localparam logic [7:0] CMD_HALT     = 8'h03;
  localparam int         TMO_W        = 24;

  typedef enum logic [2:0] {
    HUNT,
    CMD,
    ADDR_H,
    ADDR_L,
    LEN,
    DATA,
    CHK
  } state_t;

endpackage

// File: rtl/uart_rom_loader_if.sv
// Byte-wide memory write port with a req/ack handshake.
// The master holds req, addr and wdata stable until ack is seen.
interface uart_rom_loader_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;

  modport master (output mem_req, mem_addr, mem_wdata, input mem_ack);
  modport slave  (input mem_req, mem_addr, mem_wdata, output mem_ack);
endinterface

// File: rtl/uart_rom_loader.sv
// Packet controller between uart_rx and a cart ROM/RAM write port.
// It parses WRITE/RUN/HALT frames and holds the core in reset until a valid RUN arrives.
module uart_rom_loader
  import uart_rom_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 120000,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_byte,
  uart_rom_loader_if.master         mem,
  output logic                      core_run,
  output logic                      busy,
  output logic                      err_chk,
  output logic                      err_ovr,
  output logic                      err_tmo,
  input  logic                      clr_err
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

  state_t           state;
  logic             rx_valid_d;
  logic             stb;
  logic [7:0]       cmd;
  logic [7:0]       xor_acc;
  logic [15:0]      cur_addr;
  logic [8:0]       len_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  // uart_rx holds data_valid for several cycles; only its rising edge carries a byte.
  assign stb  = rx_valid & ~rx_valid_d;
  assign busy = (state != HUNT) || mem.mem_req;

  // NOTE: all state below uses non-blocking assignments so every branch sees
  // the pre-edge values; later assignments in the block take priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HUNT;
      rx_valid_d    <= 1'b0;
      cmd           <= 8'h00;
      xor_acc       <= 8'h00;
      cur_addr      <= 16'h0000;
      len_cnt       <= 9'd0;
      tmo_cnt       <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_addr  <= 16'h0000;
      mem.mem_wdata <= 8'h00;
      core_run      <= 1'b0;
      err_chk       <= 1'b0;
      err_ovr       <= 1'b0;
      err_tmo       <= 1'b0;
    end else begin
      rx_valid_d <= rx_valid;

      // Clear sits first so a same-cycle error set below overrides it.
      if (clr_err) begin
        err_chk <= 1'b0;
        err_ovr <= 1'b0;
        err_tmo <= 1'b0;
      end

      if (mem.mem_req && mem.mem_ack) begin
        mem.mem_req <= 1'b0;
        cur_addr    <= cur_addr + 16'd1;
      end

      if (stb) begin
        tmo_cnt <= '0;
        if (mem.mem_req) begin
          // Previous write still pending: drop the byte and abandon the packet.
          err_ovr <= 1'b1;
          state   <= HUNT;
        end else begin
          unique case (state)
            HUNT: begin
              if (rx_byte == SYNC_BYTE) begin
                xor_acc <= 8'h00;
                state   <= CMD;
              end
            end
            CMD: begin
              cmd     <= rx_byte;
              xor_acc <= xor_acc ^ rx_byte;
              if (rx_byte == CMD_WRITE)
                state <= ADDR_H;
              else if (rx_byte == CMD_RUN || rx_byte == CMD_HALT)
                state <= CHK;
              else
                state <= HUNT;
            end
            ADDR_H: begin
              cur_addr[15:8] <= rx_byte;
              xor_acc        <= xor_acc ^ rx_byte;
              state          <= ADDR_L;
            end
            ADDR_L: begin
              cur_addr[7:0] <= rx_byte;
              xor_acc       <= xor_acc ^ rx_byte;
              state         <= LEN;
            end
            LEN: begin
              len_cnt <= (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
              xor_acc <= xor_acc ^ rx_byte;
              state   <= DATA;
            end
            DATA: begin
              mem.mem_wdata <= rx_byte;
              mem.mem_addr  <= cur_addr;
              mem.mem_req   <= 1'b1;
              xor_acc       <= xor_acc ^ rx_byte;
              len_cnt       <= len_cnt - 9'd1;
              if (len_cnt == 9'd1)
                state <= CHK;
            end
            CHK: begin
              if (rx_byte == xor_acc) begin
                if (cmd == CMD_RUN)
                  core_run <= 1'b1;
                else if (cmd == CMD_HALT)
                  core_run <= 1'b0;
              end else begin
                err_chk <= 1'b1;
              end
              state <= HUNT;
            end
            default: state <= HUNT;
          endcase
        end
      end else if (state != HUNT) begin
        if (tmo_cnt == TMO_LAST) begin
          err_tmo <= 1'b1;
          tmo_cnt <= '0;
          state   <= HUNT;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rom_loader.sv
// Self-checking bench: packet-level reference model plus directed and random frames.
// Expected writes come from packet contents; a per-cycle process checks every handshake.
module tb_uart_rom_loader;

  localparam int unsigned TMO = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       clr_err = 1'b0;
  logic       core_run, busy, err_chk, err_ovr, err_tmo;

  uart_rom_loader_if mif();

  uart_rom_loader #(.TIMEOUT_CLKS(TMO), .SYNC_BYTE(8'h55)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .mem      (mif),
    .core_run (core_run),
    .busy     (busy),
    .err_chk  (err_chk),
    .err_ovr  (err_ovr),
    .err_tmo  (err_tmo),
    .clr_err  (clr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model state
  logic [23:0] exp_q[$];
  logic [15:0] seen_q[$];
  bit          m_run = 1'b0;
  bit          m_err_chk = 1'b0;
  bit          ack_hold = 1'b0;
  bit          random_ack = 1'b0;
  bit          random_timing = 1'b0;
  logic        req_after_stb;

  // Memory-side responder and handshake checker.
  int          wait_cnt = 0;
  int          ack_delay = 0;
  bit          prev_pending = 1'b0;
  logic [15:0] prev_addr;
  logic [7:0]  prev_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      mif.mem_ack  = 1'b0;
      wait_cnt     = 0;
      prev_pending = 1'b0;
    end else if (mif.mem_req) begin
      if (prev_pending) begin
        check("addr_stable", {16'h0, mif.mem_addr}, {16'h0, prev_addr});
        check("wdata_stable", {24'h0, mif.mem_wdata}, {24'h0, prev_data});
      end
      if (!ack_hold && wait_cnt >= ack_delay) begin
        mif.mem_ack = 1'b1;
        check("write_expected", {31'h0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0)
          check("write", {8'h0, mif.mem_addr, mif.mem_wdata}, {8'h0, exp_q.pop_front()});
        seen_q.push_back(mif.mem_addr);
        prev_pending = 1'b0;
        wait_cnt     = 0;
        ack_delay    = random_ack ? int'($urandom_range(0, 3)) : 0;
      end else begin
        mif.mem_ack  = 1'b0;
        wait_cnt++;
        prev_pending = 1'b1;
        prev_addr    = mif.mem_addr;
        prev_data    = mif.mem_wdata;
      end
    end else begin
      mif.mem_ack  = 1'b0;
      wait_cnt     = 0;
      prev_pending = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hi, input int gap, input bit clr);
    rx_byte  = b;
    rx_valid = 1'b1;
    clr_err  = clr;
    @(negedge clk);
    req_after_stb = mif.mem_req;
    clr_err = 1'b0;
    repeat (hi - 1) @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_bytes(input logic [7:0] p[$], input bit clr_last);
    for (int i = 0; i < p.size(); i++) begin
      if (random_timing)
        send_byte(p[i], int'($urandom_range(1, 3)), int'($urandom_range(5, 8)),
                  clr_last && (i == p.size() - 1));
      else
        send_byte(p[i], 1, 6, clr_last && (i == p.size() - 1));
    end
  endtask

  // Packet-level model: expected writes, checksum verdict and run/halt effect.
  task automatic model_packet(input logic [7:0] p[$], output bit good);
    logic [7:0]  x;
    logic [15:0] a;
    int          n;
    x = 8'h00;
    for (int i = 1; i < p.size() - 1; i++) x ^= p[i];
    good = (x == p[p.size() - 1]);
    if (p[1] == 8'h01) begin
      a = {p[2], p[3]};
      n = (p[4] == 8'h00) ? 256 : int'(p[4]);
      for (int i = 0; i < n; i++) exp_q.push_back({a + 16'(i), p[5 + i]});
    end
    if (!good) m_err_chk = 1'b1;
    else if (p[1] == 8'h02) m_run = 1'b1;
    else if (p[1] == 8'h03) m_run = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((busy || mif.mem_req) && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("drain_busy", {31'h0, busy}, 32'd0);
    check("drain_queue", exp_q.size(), 32'd0);
  endtask

  function automatic void add_chk(inout logic [7:0] p[$], input bit good);
    logic [7:0] x = 8'h00;
    for (int i = 1; i < p.size(); i++) x ^= p[i];
    p.push_back(good ? x : (x ^ 8'h5A));
  endfunction

  task automatic check_flags(input string tag, input bit ovr, input bit tmo);
    check({tag, "_core_run"}, {31'h0, core_run}, {31'h0, m_run});
    check({tag, "_err_chk"}, {31'h0, err_chk}, {31'h0, m_err_chk});
    check({tag, "_err_ovr"}, {31'h0, err_ovr}, {31'h0, ovr});
    check({tag, "_err_tmo"}, {31'h0, err_tmo}, {31'h0, tmo});
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_err_chk = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] p[$];
    bit         good;
    int         kind;

    repeat (3) @(negedge clk);
    check("rst_mem_req", {31'h0, mif.mem_req}, 32'd0);
    check("rst_mem_addr", {16'h0, mif.mem_addr}, 32'h0);
    check("rst_mem_wdata", {24'h0, mif.mem_wdata}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check_flags("rst", 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: WRITE C000=AA, C001=BB with immediate ack
    p = '{8'h55, 8'h01, 8'hC0, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hD2};
    model_packet(p, good);
    check("model_chk_good", {31'h0, good}, 32'd1);
    check("model_w0", {8'h0, exp_q[0]}, 32'h00C000AA);
    check("model_w1", {8'h0, exp_q[1]}, 32'h00C001BB);
    for (int i = 0; i < p.size(); i++) begin
      send_byte(p[i], 1, 6, 1'b0);
      if (i == 5) check("req_rise_after_d0", {31'h0, req_after_stb}, 32'd1);
      if (i == 3) check("busy_mid_packet", {31'h0, busy}, 32'd1);
    end
    drain();
    check_flags("t1", 1'b0, 1'b0);

    // 2: bad checksum with clear in the same cycle; then RUN and HALT
    p = '{8'h55, 8'h01, 8'hC0, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h00};
    model_packet(p, good);
    send_bytes(p, 1'b1);
    drain();
    check("t2_err_chk_set_wins", {31'h0, err_chk}, 32'd1);
    check_flags("t2", 1'b0, 1'b0);
    p = '{8'h55, 8'h02, 8'h02};
    model_packet(p, good);
    send_bytes(p, 1'b0);
    check("t2_run", {31'h0, core_run}, 32'd1);
    p = '{8'h55, 8'h03, 8'h03};
    model_packet(p, good);
    send_bytes(p, 1'b0);
    check("t2_halt", {31'h0, core_run}, 32'd0);
    pulse_clr();
    check_flags("t2_clr", 1'b0, 1'b0);

    // 3: overrun while D0 is still pending
    ack_hold = 1'b1;
    exp_q.push_back(24'hC000AA);
    p = '{8'h55, 8'h01, 8'hC0, 8'h00, 8'h02, 8'hAA, 8'hBB};
    send_bytes(p, 1'b0);
    check("t3_err_ovr", {31'h0, err_ovr}, 32'd1);
    check("t3_req_pending", {31'h0, mif.mem_req}, 32'd1);
    ack_hold = 1'b0;
    drain();
    send_byte(8'hD2, 1, 6, 1'b0);
    check("t3_hunt_after_ovr", {31'h0, busy}, 32'd0);
    check_flags("t3", 1'b1, 1'b0);
    pulse_clr();

    // 4: inter-byte timeout, then a valid packet
    p = '{8'h55, 8'h01, 8'hC0};
    send_bytes(p, 1'b0);
    check("t4_busy_before", {31'h0, busy}, 32'd1);
    repeat (TMO - 20) @(negedge clk);
    check("t4_no_early_tmo", {31'h0, err_tmo}, 32'd0);
    repeat (40) @(negedge clk);
    check("t4_busy_after", {31'h0, busy}, 32'd0);
    check_flags("t4", 1'b0, 1'b1);
    p = '{8'h55, 8'h01, 8'h12, 8'h34, 8'h01, 8'h77};
    add_chk(p, 1'b1);
    model_packet(p, good);
    send_bytes(p, 1'b0);
    drain();
    check_flags("t4_after", 1'b0, 1'b1);
    pulse_clr();

    // 5: LEN=0 at FFFF wraps through 0000..00FE
    p = '{8'h55, 8'h01, 8'hFF, 8'hFF, 8'h00};
    for (int i = 0; i < 256; i++) p.push_back(8'($urandom));
    add_chk(p, 1'b1);
    model_packet(p, good);
    seen_q.delete();
    random_ack = 1'b1;
    send_bytes(p, 1'b0);
    drain();
    check("t5_count", seen_q.size(), 32'd256);
    check("t5_first", {16'h0, seen_q[0]}, 32'h0000FFFF);
    check("t5_second", {16'h0, seen_q[1]}, 32'h00000000);
    check("t5_last", {16'h0, seen_q[255]}, 32'h000000FE);
    check_flags("t5", 1'b0, 1'b0);

    // Random packets
    random_timing = 1'b1;
    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(0, 9));
      p.delete();
      if (kind < 6) begin
        p = '{8'h55, 8'h01, 8'($urandom), 8'($urandom), 8'($urandom_range(1, 8))};
        for (int i = 0; i < int'(p[4]); i++) p.push_back(8'($urandom));
        add_chk(p, $urandom_range(0, 4) != 0);
        model_packet(p, good);
      end else if (kind < 8) begin
        p = '{8'h55, (kind == 6) ? 8'h02 : 8'h03};
        add_chk(p, $urandom_range(0, 4) != 0);
        model_packet(p, good);
      end else if (kind == 8) begin
        p = '{8'h55, 8'($urandom_range(4, 255))};
      end else begin
        p = '{8'($urandom_range(0, 8'h54))};
      end
      send_bytes(p, 1'b0);
      drain();
      check_flags("rand", 1'b0, 1'b0);
      if ($urandom_range(0, 5) == 0) pulse_clr();
    end
    random_timing = 1'b0;

    // 6: asynchronous reset during a pending write; multi-cycle rx_valid
    p = '{8'h55, 8'h02, 8'h02};
    model_packet(p, good);
    send_bytes(p, 1'b0);
    check("t6_run_before", {31'h0, core_run}, 32'd1);
    ack_hold = 1'b1;
    p = '{8'h55, 8'h01, 8'hC0, 8'h00, 8'h02, 8'hAA};
    send_bytes(p, 1'b0);
    check("t6_req_pending", {31'h0, mif.mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_req_async_drop", {31'h0, mif.mem_req}, 32'd0);
    check("t6_core_run", {31'h0, core_run}, 32'd0);
    check("t6_busy", {31'h0, busy}, 32'd0);
    exp_q.delete();
    ack_hold  = 1'b0;
    m_run     = 1'b0;
    m_err_chk = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    seen_q.delete();
    p = '{8'h55, 8'h02, 8'h02};
    model_packet(p, good);
    for (int i = 0; i < p.size(); i++) send_byte(p[i], 3, 5, 1'b0);
    drain();
    check("t6_one_byte_per_edge", {31'h0, core_run}, 32'd1);
    check("t6_no_stray_write", seen_q.size(), 32'd0);
    check_flags("t6", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
